multi_clock_enable_divider: RTL and testbench

- Parametrised, fully synchronous successor to the ripple clock divider.
- Generates NUM_CH independent divided outputs from the single system clock. Each channel provides:
  - a one-cycle tick (clock-enable pulse);
  - a registered square-wave level.
- Each channel has its own runtime-programmable divide ratio, so no derived clocks are used as clock pins.
- Feeds game-logic timing, such as sprite animation, sound and debounce, as enables in the clk domain.

---
 rtl/multi_clock_enable_divider_if.sv | 25 ++
 rtl/multi_clock_enable_divider.sv | 158 +++++++++++++++
 tb/tb_multi_clock_enable_divider.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/multi_clock_enable_divider_if.sv
// Configuration bus for the multi-channel clock-enable divider: a divisor
// write strobe with channel select and value, plus the rejected-write flag.
interface multi_clock_enable_divider_if #(
    parameter int CNT_W = 16,
    parameter int CH_W  = 2
);
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_err;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_div,
        input  cfg_err
    );

    modport slave (
        input  cfg_we,
        input  cfg_ch,
        input  cfg_div,
        output cfg_err
    );
endinterface

// File: rtl/multi_clock_enable_divider.sv
// Multi-channel synchronous clock-enable divider. Every channel counts the
// system clock against its own live divisor and produces a one-cycle tick per
// period plus a registered square-wave level. Divisor changes on a running
// channel are held in a shadow register and committed at the period wrap, so
// a period is never cut short.
module multi_clock_enable_divider #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 restart,
    multi_clock_enable_divider_if.slave          cfg,
    output logic [NUM_CH-1:0]                    tick,
    output logic [NUM_CH-1:0]                    clk_out,
    output logic [NUM_CH-1:0]                    active
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [31:0] ch_ext_s;
    logic        wr_ok_s;
    logic        cfg_err_r;

    // Decode whether the current write targets an existing channel.
    always_comb begin
        ch_ext_s = 32'(cfg.cfg_ch);
        if (ch_ext_s < 32'(NUM_CH)) begin
            wr_ok_s = cfg.cfg_we;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Flag for one cycle any write addressed past the last channel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= cfg.cfg_we && (ch_ext_s >= 32'(NUM_CH));
        end
    end

    assign cfg.cfg_err = cfg_err_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] div_r;
        logic [CNT_W-1:0] sdiv_r;
        logic             pend_r;
        logic             tick_r;
        logic             clk_out_r;
        logic             active_r;

        logic [CNT_W-1:0] cnt_s;
        logic [CNT_W-1:0] div_s;
        logic [CNT_W-1:0] sdiv_s;
        logic [CNT_W-1:0] half_s;
        logic             pend_s;
        logic             tick_s;
        logic             clk_out_s;
        logic             hit_s;

        // Next-state for this channel: restart, immediate load of a disabled
        // channel, shadow write, and counting with commit at the wrap edge.
        always_comb begin
            hit_s     = wr_ok_s && (ch_ext_s == 32'(i));
            cnt_s     = cnt_r;
            div_s     = div_r;
            sdiv_s    = sdiv_r;
            pend_s    = pend_r;
            tick_s    = 1'b0;
            clk_out_s = clk_out_r;
            half_s    = ZERO;
            if (restart) begin
                if (hit_s) begin
                    div_s = cfg.cfg_div;
                end else if (pend_r) begin
                    div_s = sdiv_r;
                end else begin
                    div_s = div_r;
                end
                pend_s    = 1'b0;
                cnt_s     = ZERO;
                clk_out_s = (div_s != ZERO);
            end else if (hit_s && (div_r == ZERO)) begin
                div_s     = cfg.cfg_div;
                cnt_s     = ZERO;
                clk_out_s = 1'b0;
            end else begin
                if (hit_s) begin
                    sdiv_s = cfg.cfg_div;
                    pend_s = 1'b1;
                end else begin
                    sdiv_s = sdiv_r;
                end
                if (enable && (div_r != ZERO)) begin
                    if (cnt_r >= (div_r - ONE)) begin
                        cnt_s  = ZERO;
                        tick_s = 1'b1;
                        // A write landing on the wrap edge takes effect now.
                        if (hit_s) begin
                            div_s  = cfg.cfg_div;
                            pend_s = 1'b0;
                        end else if (pend_r) begin
                            div_s  = sdiv_r;
                            pend_s = 1'b0;
                        end else begin
                            div_s = div_r;
                        end
                    end else begin
                        cnt_s = cnt_r + ONE;
                    end
                    // ceil(D/2) without the overflow of (D+1)>>1.
                    half_s    = (div_s >> 1) + {{(CNT_W-1){1'b0}}, div_s[0]};
                    clk_out_s = (cnt_s < half_s);
                end else if (div_r == ZERO) begin
                    cnt_s     = ZERO;
                    clk_out_s = 1'b0;
                end else begin
                    cnt_s     = cnt_r;
                    clk_out_s = clk_out_r;
                end
            end
        end

        // Channel state and registered outputs.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_r     <= ZERO;
                div_r     <= DIV_RST;
                sdiv_r    <= DIV_RST;
                pend_r    <= 1'b0;
                tick_r    <= 1'b0;
                clk_out_r <= 1'b0;
                active_r  <= (DIV_RST != ZERO);
            end else begin
                cnt_r     <= cnt_s;
                div_r     <= div_s;
                sdiv_r    <= sdiv_s;
                pend_r    <= pend_s;
                tick_r    <= tick_s;
                clk_out_r <= clk_out_s;
                active_r  <= (div_s != ZERO);
            end
        end

        assign tick[i]    = tick_r;
        assign clk_out[i] = clk_out_r;
        assign active[i]  = active_r;
    end

endmodule

// File: tb/tb_multi_clock_enable_divider.sv
// Self-checking bench for multi_clock_enable_divider: directed scenarios and
// random traffic compared against a period/phase reference model.
module tb_multi_clock_enable_divider;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int CH_W   = 3;
    localparam int DEF    = 2;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              restart;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] active;

    multi_clock_enable_divider_if #(.CNT_W(CNT_W), .CH_W(CH_W)) cfg_bus ();

    multi_clock_enable_divider #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF), .CH_W(CH_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart),
        .cfg(cfg_bus.slave), .tick(tick), .clk_out(clk_out), .active(active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position within the period and the period length.
    int pos  [NUM_CH];
    int per  [NUM_CH];
    int nper [NUM_CH];
    bit waiting [NUM_CH];
    logic [NUM_CH-1:0] e_tick, e_clk, e_act;
    logic e_err;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            pos[i] = 0; per[i] = DEF; nper[i] = DEF; waiting[i] = 0;
        end
        e_tick = '0; e_clk = '0; e_err = 1'b0;
        for (int i = 0; i < NUM_CH; i++) e_act[i] = (DEF != 0);
    endfunction

    function automatic void model_step(bit en, bit rs, bit we, int ch, int dv);
        bit hit;
        e_err = we && (ch >= NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
            hit = we && (ch == i);
            e_tick[i] = 1'b0;
            if (rs) begin
                if (hit) per[i] = dv;
                else if (waiting[i]) per[i] = nper[i];
                waiting[i] = 0;
                pos[i] = 0;
                e_clk[i] = (per[i] != 0);
            end else if (hit && per[i] == 0) begin
                per[i] = dv;
                pos[i] = 0;
                e_clk[i] = 1'b0;
            end else begin
                if (hit) begin nper[i] = dv; waiting[i] = 1; end
                if (per[i] == 0) begin
                    e_clk[i] = 1'b0;
                end else if (en) begin
                    pos[i] = pos[i] + 1;
                    if (pos[i] == per[i]) begin
                        pos[i] = 0;
                        e_tick[i] = 1'b1;
                        if (waiting[i]) begin per[i] = nper[i]; waiting[i] = 0; end
                    end
                    e_clk[i] = (per[i] != 0) && (pos[i] < (per[i] + 1) / 2);
                end
            end
            e_act[i] = (per[i] != 0);
        end
    endfunction

    task automatic cycle(input bit en, input bit rs, input bit we, input int ch, input int dv);
        enable = en; restart = rs;
        cfg_bus.cfg_we = we; cfg_bus.cfg_ch = CH_W'(ch); cfg_bus.cfg_div = CNT_W'(dv);
        @(posedge clk); #1;
        model_step(en, rs, we, ch, dv);
        check_eq("tick",    32'(tick),            32'(e_tick));
        check_eq("clk_out", 32'(clk_out),         32'(e_clk));
        check_eq("active",  32'(active),          32'(e_act));
        check_eq("cfg_err", 32'(cfg_bus.cfg_err), 32'(e_err));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tick"}, 32'(tick),            32'h0);
        check_eq({tag, "_clk"},  32'(clk_out),         32'h0);
        check_eq({tag, "_err"},  32'(cfg_bus.cfg_err), 32'h0);
        check_eq({tag, "_act"},  32'(active),          32'hF);
    endtask

    initial begin
        int n;
        bit seen;
        reset = 1'b0; enable = 1'b0; restart = 1'b0;
        cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_ch = '0; cfg_bus.cfg_div = '0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk); reset = 1'b1;

        // Default divide-by-2: first tick on the second edge.
        idle(8);

        // Reprogram ch1 to 5 mid-period; current period completes first.
        cycle(1'b1, 1'b0, 1'b1, 1, 5);
        idle(16);

        // Divide-by-4 on ch0, then freeze for 7 cycles mid-period.
        cycle(1'b1, 1'b0, 1'b1, 0, 4);
        seen = 0;
        for (int k = 0; k < 12 && !seen; k++) begin
            idle(1);
            seen = tick[0];
        end
        check_eq("ch0_tick_seen", 32'(seen), 32'h1);
        idle(1);
        for (int k = 0; k < 7; k++) cycle(1'b0, 1'b0, 1'b0, 0, 0);
        n = 0; seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            idle(1); n++;
            seen = tick[0];
        end
        check_eq("hold_remaining", 32'(n), 32'd3);

        // Disable ch2, then load 3: first tick 4 edges after the write.
        cycle(1'b1, 1'b0, 1'b1, 2, 0);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            idle(1);
            seen = !active[2];
        end
        check_eq("ch2_disabled", 32'(active[2]), 32'h0);
        idle(2);
        check_eq("ch2_off_clk", 32'(clk_out[2]), 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 2, 3);
        n = 1; seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            idle(1); n++;
            seen = tick[2];
        end
        check_eq("ch2_first_tick", 32'(n), 32'd4);

        // 3/4/5/6 then restart: aligned high phase, all ticks meet at 60.
        cycle(1'b1, 1'b0, 1'b1, 0, 3);
        cycle(1'b1, 1'b0, 1'b1, 1, 4);
        cycle(1'b1, 1'b0, 1'b1, 2, 5);
        cycle(1'b1, 1'b1, 1'b1, 3, 6);
        check_eq("restart_align", 32'(clk_out), 32'hF);
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            idle(1);
            if (tick == 4'hF && n == 0) n = k;
        end
        check_eq("lcm_ticks", 32'(n), 32'd60);

        // Write to a nonexistent channel.
        cycle(1'b1, 1'b0, 1'b1, NUM_CH, 9);
        check_eq("bad_ch_err", 32'(cfg_bus.cfg_err), 32'h1);
        idle(1);
        check_eq("bad_ch_err_clr", 32'(cfg_bus.cfg_err), 32'h0);
        idle(6);

        // Asynchronous reset between edges.
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async_reset");
        @(negedge clk); reset = 1'b1;
        idle(4);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 5) == 0),
                  int'($urandom_range(0, NUM_CH + 1)),
                  int'($urandom_range(0, 9)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
